mem_sequencer: RTL

Initiator-side sequencer for the single-port data memory. It accepts load and store requests from the datapath over a valid/ready handshake and drives the memory's `address`, `data` and `we` inputs. It samples the memory's `data_out`, which the memory updates on the falling clock edge. Read data returns to the datapath on a buffered response channel with backpressure, including multi-word incrementing read bursts.

---
 rtl/mem_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// Initiator-side sequencer for a single-port data memory with a falling-edge read port.
// Serves single-word stores and incrementing read bursts, returning data over a held response channel.
module mem_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_data;
    logic                  r_mem_we;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_last;
    logic [LEN_WIDTH-1:0]  r_count;

    logic w_idle;
    logic w_last_beat;

    assign w_idle      = (r_state == S_IDLE);
    assign w_last_beat = (r_count == '0);

    // Ready is gated by rst so nothing is accepted on a reset edge.
    assign req_ready   = w_idle & ~rst;
    assign busy        = ~w_idle & ~rst;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_last    = r_rsp_last;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign mem_we      = r_mem_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_we      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_last    <= 1'b0;
            r_count       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mem_address <= req_addr;
                        if (req_we) begin
                            r_mem_data <= req_wdata;
                            r_mem_we   <= 1'b1;
                            r_state    <= S_WRITE;
                        end else begin
                            r_count    <= req_len;
                            r_mem_we   <= 1'b0;
                            r_state    <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_state  <= S_IDLE;
                end
                S_READ: begin
                    // The memory refreshed data_out on the falling edge mid-cycle.
                    r_rsp_data  <= mem_data_out;
                    r_rsp_valid <= 1'b1;
                    r_rsp_last  <= w_last_beat;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_last_beat) begin
                            r_rsp_last <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_mem_address <= r_mem_address + 1'b1;
                            r_count       <= r_count - 1'b1;
                            r_state       <= S_READ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
